in_ctrl_tapline: RTL
====================

// Module: in_ctrl_tapline
// PURPOSE
//  Parametrised input tap delay line for the FIR front end. Shifts in one
//  binary sample per accepted cycle and exposes NUM_CH tap sets: channel c
//  taps the line at stride c+1 for decimated/polyphase filters.
//  Adds valid gating, sync clear, per-channel fill status and decimation strobes.
//  Sits between the sample source and the SC/binary multiplier arrays.
// PARAMETERS
//  WIDTH   8   sample width in bits
//  TAPS    39  taps per channel (filter order+1)
//  NUM_CH  4   channel count; channel c stride = c+1
//  DEPTH   NUM_CH*TAPS  (localparam) line length, line[0] = newest
// PORTS
//  clock      in   1               rising-edge clock
//  reset      in   1               async, active-high
//  in_valid   in   1               sample accept strobe
//  in         in   WIDTH           binary sample
//  clear      in   1               sync flush of line and counters
//  out        out  [NUM_CH][TAPS]xWIDTH  out[c][t] = line[(t+1)*(c+1)-1]
//  ch_full    out  NUM_CH          channel c holds TAPS valid taps
//  dec_strobe out  NUM_CH          1-cycle pulse: channel c output phase
//  fill_cnt   out  $clog2(DEPTH+1) accepted samples, saturating at DEPTH
// BEHAVIOUR
//  - Reset (async, active-high): line, fill_cnt, phase counters, ch_full,
//    dec_strobe all 0; so every out[c][t] = 0.
//  - Accept edge = rising clock with in_valid=1 and clear=0:
//    line[0]<=in, line[i]<=line[i-1]; fill_cnt<=min(fill_cnt+1,DEPTH).
//    No accept: line and fill_cnt hold.
//  - Latency: sample accepted at edge k is on line[0] after edge k; reaches
//    out[c][t] after (t+1)*(c+1) accept edges.
//  - ch_full[c] = (fill_cnt >= TAPS*(c+1)); registered, updated with fill_cnt.
//  - Phase: ph[c] in 0..c, increments mod c+1 on each accept edge.
//    dec_strobe[c] registered: 1 for the cycle after an accept edge where
//    ph[c] wraps to 0 and post-update fill_cnt >= TAPS*(c+1); else 0.
//    Channel 0 strobes on every accept once full.
//  - clear=1 at an edge: line, fill_cnt, ph, ch_full, dec_strobe <= 0.
//    clear beats in_valid in the same cycle; that sample is dropped.
//  - fill_cnt saturates at DEPTH; ph keeps wrapping; line keeps shifting.
//  - Reset mid-stream discards all state immediately (async), no partial taps.
//  - Data is opaque (no arithmetic); widths preserved end to end.
// CONFIGURATION
//  TAPLINE_OUT_REG_EN defined: out, ch_full, dec_strobe each get one extra
//   register stage (reset 0, cleared by clear); all relations above hold
//   one cycle later, timing aligned among the three.
//  Not defined: out driven combinationally from line registers; ch_full and
//   dec_strobe as specified above.
// STRUCTURE
//  Shared package in_ctrl_pkg: tap-index function tap_idx(c,t)=(t+1)*(c+1)-1,
//   fill-count width function, default WIDTH/TAPS/NUM_CH constants.
//  One sub-module: in_ctrl_phase_cnt (per-channel mod-(c+1) phase counter
//   with wrap flag), instantiated NUM_CH times in a generate loop.
//  Line itself is a flat register array in the top module.
// TESTING (bench params WIDTH=8, TAPS=4, NUM_CH=2, DEPTH=8)
//  1 reset then feed 1..8 with in_valid=1 -> out[0]={8,7,6,5},
//    out[1]={7,5,3,1}; fill_cnt=8; ch_full=2'b11.
//  2 feed 1..4 -> ch_full=2'b01 after 4th accept; 2'b11 after 8th accept.
//  3 in_valid toggled 1,0,1,0 with in 1..n -> line and fill_cnt advance only
//    on valid cycles; held values unchanged on idle cycles.
//  4 after fill, 6 more accepts -> dec_strobe[0] pulses 6 times,
//    dec_strobe[1] pulses 3 times (every 2nd accept); fill_cnt stays 8.
//  5 clear=1 with in_valid=1, in=0xAA -> all out=0, fill_cnt=0, ch_full=0,
//    0xAA not in line.
//  6 assert reset mid-stream between edges -> outputs 0 immediately, before
//    next edge; resume 1..4 -> out[0]={4,3,2,1}.
//  Rerun 1,4,6 with TAPLINE_OUT_REG_EN: same values one cycle later.

Source files
------------

// File: rtl/in_ctrl_pkg.sv
// Shared constants and index helpers for the input tap delay line.
package in_ctrl_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_TAPS   = 39;
  localparam int unsigned DEF_NUM_CH = 4;

  // Line position feeding tap t of channel c (stride c+1)
  function automatic int unsigned tap_idx(input int unsigned c, input int unsigned t);
    return (t + 1) * (c + 1) - 1;
  endfunction

  function automatic int unsigned fill_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ph_w(input int unsigned modulus);
    return (modulus < 2) ? 1 : $clog2(modulus);
  endfunction

endpackage

// File: rtl/in_ctrl_phase_cnt.sv
// Mod-MOD phase counter advancing on i_adv; o_wrap flags the advance that returns it to 0.
module in_ctrl_phase_cnt
  import in_ctrl_pkg::*;
#(
  parameter int unsigned MOD = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_adv,
  output logic o_wrap
);

  localparam int unsigned PW = ph_w(MOD);

  logic [PW-1:0] r_ph;

  assign o_wrap = i_adv & (r_ph == PW'(MOD - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ph <= '0;
    end else if (i_clr) begin
      r_ph <= '0;
    end else if (i_adv) begin
      r_ph <= o_wrap ? '0 : r_ph + PW'(1);
    end
  end

endmodule

// File: rtl/in_ctrl_tapline.sv
// Input tap delay line with NUM_CH strided tap sets, fill status and decimation strobes.
// Define TAPLINE_OUT_REG_EN to add one aligned register stage on out/ch_full/dec_strobe.
module in_ctrl_tapline
  import in_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned TAPS   = DEF_TAPS,
  parameter int unsigned NUM_CH = DEF_NUM_CH
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   in_valid,
  input  logic [WIDTH-1:0]                       in,
  input  logic                                   clear,
  output logic [NUM_CH-1:0][TAPS-1:0][WIDTH-1:0] out,
  output logic [NUM_CH-1:0]                      ch_full,
  output logic [NUM_CH-1:0]                      dec_strobe,
  output logic [fill_w(NUM_CH*TAPS)-1:0]         fill_cnt
);

  localparam int unsigned DEPTH = NUM_CH * TAPS;
  localparam int unsigned FW    = fill_w(DEPTH);

  logic [WIDTH-1:0]                       r_line [DEPTH];
  logic [FW-1:0]                          r_fill;
  logic [FW-1:0]                          w_fill_nxt;
  logic                                   w_accept;
  logic [NUM_CH-1:0]                      w_wrap;
  logic [NUM_CH-1:0]                      w_full_nxt;
  logic [NUM_CH-1:0]                      w_strobe_nxt;
  logic [NUM_CH-1:0]                      r_full;
  logic [NUM_CH-1:0]                      r_strobe;
  logic [NUM_CH-1:0][TAPS-1:0][WIDTH-1:0] w_out;

  assign w_accept = in_valid & ~clear;
  assign fill_cnt = r_fill;

  always_comb begin
    w_fill_nxt = r_fill;
    if (clear) begin
      w_fill_nxt = '0;
    end else if (w_accept && (r_fill != FW'(DEPTH))) begin
      w_fill_nxt = r_fill + FW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_line[i] <= '0;
      r_fill <= '0;
    end else begin
      r_fill <= w_fill_nxt;
      if (clear) begin
        for (int unsigned i = 0; i < DEPTH; i++) r_line[i] <= '0;
      end else if (w_accept) begin
        r_line[0] <= in;
        for (int unsigned i = 1; i < DEPTH; i++) r_line[i] <= r_line[i-1];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int unsigned THR = TAPS * (c + 1);

    in_ctrl_phase_cnt #(
      .MOD (c + 1)
    ) u_phase (
      .i_clk  (clock),
      .i_rst  (reset),
      .i_clr  (clear),
      .i_adv  (w_accept),
      .o_wrap (w_wrap[c])
    );

    // Status tracks the post-update count so it lands on the same edge as fill_cnt
    assign w_full_nxt[c]   = (w_fill_nxt >= FW'(THR));
    assign w_strobe_nxt[c] = w_wrap[c] & w_full_nxt[c];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_full   <= '0;
      r_strobe <= '0;
    end else begin
      r_full   <= w_full_nxt;
      r_strobe <= w_strobe_nxt;
    end
  end

  always_comb begin
    w_out = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned t = 0; t < TAPS; t++) begin
        w_out[c][t] = r_line[tap_idx(c, t)];
      end
    end
  end

`ifdef TAPLINE_OUT_REG_EN
  logic [NUM_CH-1:0][TAPS-1:0][WIDTH-1:0] r_out;
  logic [NUM_CH-1:0]                      r_full_q;
  logic [NUM_CH-1:0]                      r_strobe_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out      <= '0;
      r_full_q   <= '0;
      r_strobe_q <= '0;
    end else if (clear) begin
      r_out      <= '0;
      r_full_q   <= '0;
      r_strobe_q <= '0;
    end else begin
      r_out      <= w_out;
      r_full_q   <= r_full;
      r_strobe_q <= r_strobe;
    end
  end

  assign out        = r_out;
  assign ch_full    = r_full_q;
  assign dec_strobe = r_strobe_q;
`else
  assign out        = w_out;
  assign ch_full    = r_full;
  assign dec_strobe = r_strobe;
`endif

endmodule
